// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter slice: next-PC source encoding
// and default vectors.
package pc_pkg;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_PEND,
    SRC_JUMP,
    SRC_RET,
    SRC_BRANCH,
    SRC_EXC
  } next_src_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;
  localparam int          DEF_PC_STEP      = 4;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack: pushes past full overwrite the oldest entry,
// a simultaneous push/pop replaces the top in place.
module return_addr_stack #(
  parameter int ADDR_WIDTH = 32,
  parameter int RAS_DEPTH  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  output logic [ADDR_WIDTH-1:0] top_addr,
  output logic                  empty,
  output logic                  full
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_WIDTH-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]      top;
  logic [CNT_W-1:0]      count;
  logic                  swap;
  logic [PTR_W-1:0]      wr_idx;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(RAS_DEPTH));
  assign top_addr = mem[top];

  // A pop on an empty stack is ignored, so push+pop then degrades to a push.
  assign swap   = push && pop && !empty;
  assign wr_idx = swap ? top : top + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      top   <= '0;
      count <= '0;
    end else if (push && !swap) begin
      top <= top + 1'b1;
      if (!full) count <= count + 1'b1;
    end else if (pop && !push && !empty) begin
      top   <= top - 1'b1;
      count <= count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_idx] <= push_addr;
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with prioritised redirect sources, stall-deferred redirect
// and a return-address stack for call/return prediction.
module pc_unit
  import pc_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(DEF_RESET_VECTOR),
  parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR   = ADDR_WIDTH'(DEF_EXC_VECTOR),
  parameter int                    PC_STEP      = DEF_PC_STEP,
  parameter int                    RAS_DEPTH    = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  exception,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  jump_en,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  input  logic                  ret_pop,
  input  logic                  link_push,
  input  logic [ADDR_WIDTH-1:0] link_addr,
  output logic [ADDR_WIDTH-1:0] inst_address,
  output logic [ADDR_WIDTH-1:0] pc_plus_step,
  output logic                  misaligned,
  output logic                  ras_empty,
  output logic                  ras_full
);

  next_src_e             src;
  logic                  redir_any;
  logic [ADDR_WIDTH-1:0] ras_top;
  logic [ADDR_WIDTH-1:0] ret_tgt;
  logic [ADDR_WIDTH-1:0] redir_tgt;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic                  pend_vld;
  logic [ADDR_WIDTH-1:0] pend_tgt;

  return_addr_stack #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock    (clock),
    .reset    (reset),
    .push     (link_push),
    .pop      (ret_pop),
    .push_addr(link_addr),
    .top_addr (ras_top),
    .empty    (ras_empty),
    .full     (ras_full)
  );

  assign pc_plus_step = inst_address + ADDR_WIDTH'(PC_STEP);
  assign misaligned   = (inst_address[1:0] != 2'b00);
  assign redir_any    = branch_taken || ret_pop || jump_en;
  assign ret_tgt      = ras_empty ? jump_target : ras_top;

  always_comb begin
    src = SRC_SEQ;
    if (exception)         src = SRC_EXC;
    else if (branch_taken) src = SRC_BRANCH;
    else if (ret_pop)      src = SRC_RET;
    else if (jump_en)      src = SRC_JUMP;
    else if (pend_vld)     src = SRC_PEND;
  end

  // Redirect target among the sources that may be deferred by a stall.
  always_comb begin
    redir_tgt = jump_target;
    if (branch_taken) redir_tgt = branch_target;
    else if (ret_pop) redir_tgt = ret_tgt;
  end

  always_comb begin
    next_pc = pc_plus_step;
    case (src)
      SRC_EXC:                     next_pc = EXC_VECTOR;
      SRC_BRANCH, SRC_RET, SRC_JUMP: next_pc = redir_tgt;
      SRC_PEND:                    next_pc = pend_tgt;
      default:                     next_pc = pc_plus_step;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inst_address <= RESET_VECTOR;
      pend_vld     <= 1'b0;
    end else if (exception) begin
      inst_address <= EXC_VECTOR;
      pend_vld     <= 1'b0;
    end else if (stall) begin
      if (redir_any) pend_vld <= 1'b1;
    end else begin
      inst_address <= next_pc;
      pend_vld     <= 1'b0;
    end
  end

  // Target payload is qualified by pend_vld, so it needs no reset.
  always_ff @(posedge clock) begin
    if (stall && !exception && redir_any) pend_tgt <= redir_tgt;
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: sequential fetch, redirect priority, stall
// deferral, RAS push/pop/overflow, wrap-around and misalignment.
module tb_pc_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall, exception, branch_taken, jump_en, ret_pop, link_push;
  logic [31:0] branch_target, jump_target, link_addr;
  logic [31:0] inst_address, pc_plus_step;
  logic        misaligned, ras_empty, ras_full;

  int n_vec = 0;
  int n_bad = 0;

  pc_unit dut (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .exception    (exception),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump_en      (jump_en),
    .jump_target  (jump_target),
    .ret_pop      (ret_pop),
    .link_push    (link_push),
    .link_addr    (link_addr),
    .inst_address (inst_address),
    .pc_plus_step (pc_plus_step),
    .misaligned   (misaligned),
    .ras_empty    (ras_empty),
    .ras_full     (ras_full)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    stall = 0; exception = 0; branch_taken = 0; jump_en = 0;
    ret_pop = 0; link_push = 0;
  endtask

  task automatic go_to(input logic [31:0] a);
    idle();
    branch_taken = 1; branch_target = a;
    step();
    branch_taken = 0;
  endtask

  initial begin
    reset = 1; idle();
    branch_target = 0; jump_target = 0; link_addr = 0;
    #2;
    check("rst_pc", inst_address, 32'h0);
    check("rst_empty", 32'(ras_empty), 32'h1);
    check("rst_full", 32'(ras_full), 32'h0);
    check("rst_misal", 32'(misaligned), 32'h0);
    @(posedge clock); #2;
    reset = 0;
    check("seq0", inst_address, 32'h0);
    step(); check("seq1", inst_address, 32'h4);
    step(); check("seq2", inst_address, 32'h8);
    step(); check("seq3", inst_address, 32'hC);

    // asynchronous reset between edges
    reset = 1; #1;
    check("async_rst", inst_address, 32'h0);
    #1; reset = 0;
    step(); step(); step(); step();
    check("seq_0x10", inst_address, 32'h10);

    // branch beats jump
    branch_taken = 1; branch_target = 32'h40;
    jump_en = 1; jump_target = 32'h80;
    step(); idle();
    check("br_over_jmp", inst_address, 32'h40);
    step(); check("after_br", inst_address, 32'h44);

    // stall with deferred branch
    go_to(32'h20);
    check("at_0x20", inst_address, 32'h20);
    stall = 1; branch_taken = 1; branch_target = 32'h100;
    step(); branch_taken = 0;
    check("stall_hold0", inst_address, 32'h20);
    step(); check("stall_hold1", inst_address, 32'h20);
    step(); check("stall_hold2", inst_address, 32'h20);
    stall = 0;
    step(); check("pend_apply", inst_address, 32'h100);
    step(); check("pend_clear", inst_address, 32'h104);

    // newer redirect during stall overwrites pending; new redirect at release wins
    stall = 1; branch_taken = 1; branch_target = 32'h500;
    step(); branch_taken = 0; jump_en = 1; jump_target = 32'h600;
    step(); jump_en = 0;
    check("pend_ovr_hold", inst_address, 32'h104);
    stall = 0; branch_taken = 1; branch_target = 32'h700;
    step(); branch_taken = 0;
    check("new_wins", inst_address, 32'h700);
    step(); check("pend_dropped", inst_address, 32'h704);

    // exception during stall, pending discarded
    go_to(32'h20);
    stall = 1; branch_taken = 1; branch_target = 32'h200;
    step(); branch_taken = 0;
    exception = 1;
    step(); exception = 0; stall = 0;
    check("exc_in_stall", inst_address, 32'h8000_0180);
    step(); check("exc_pend_clr", inst_address, 32'h8000_0184);

    // RAS fill past depth
    idle(); link_push = 1;
    link_addr = 32'hA0; step();
    check("ras_nonempty", 32'(ras_empty), 32'h0);
    link_addr = 32'hB0; step();
    link_addr = 32'hC0; step();
    check("ras_not_full3", 32'(ras_full), 32'h0);
    link_addr = 32'hD0; step();
    check("ras_full4", 32'(ras_full), 32'h1);
    link_addr = 32'hE0; step();
    check("ras_full5", 32'(ras_full), 32'h1);
    link_push = 0;

    ret_pop = 1; jump_target = 32'h300;
    step(); check("pop1", inst_address, 32'hE0);
    check("not_full", 32'(ras_full), 32'h0);
    step(); check("pop2", inst_address, 32'hD0);
    step(); check("pop3", inst_address, 32'hC0);
    step(); check("pop4", inst_address, 32'hB0);
    check("ras_empty4", 32'(ras_empty), 32'h1);
    step(); check("pop_empty", inst_address, 32'h300);
    check("ras_still_empty", 32'(ras_empty), 32'h1);
    ret_pop = 0;

    // simultaneous push and pop
    link_push = 1; link_addr = 32'h50; step();
    ret_pop = 1; link_addr = 32'h60; jump_target = 32'h900;
    step(); link_push = 0;
    check("swap_tgt", inst_address, 32'h50);
    check("swap_cnt_ne", 32'(ras_empty), 32'h0);
    step(); ret_pop = 0;
    check("swap_top", inst_address, 32'h60);
    check("swap_cnt1", 32'(ras_empty), 32'h1);

    // return beats jump
    link_push = 1; link_addr = 32'h1234; step(); link_push = 0;
    ret_pop = 1; jump_en = 1; jump_target = 32'h880;
    step(); idle();
    check("ret_over_jmp", inst_address, 32'h1234);

    // wrap-around and misaligned target
    go_to(32'hFFFF_FFFC);
    check("pps_wrap", pc_plus_step, 32'h0);
    step(); check("pc_wrap", inst_address, 32'h0);
    go_to(32'h42);
    check("misal_pc", inst_address, 32'h42);
    check("misal_flag", 32'(misaligned), 32'h1);
    check("misal_pps", pc_plus_step, 32'h46);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
